// File: rtl/imem_pkg.sv
// Shared types and defaults for the loadable instruction memory.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_e;

    localparam int              IMEM_DEF_DATA_W = 16;
    localparam logic [IMEM_DEF_DATA_W-1:0] IMEM_NOP = '0;

endpackage

// File: rtl/imem_sp_ram.sv
// Single-port RAM: synchronous write, registered read that holds when not enabled.
module imem_sp_ram #(
    parameter int    DATA_W    = 16,
    parameter int    DEPTH     = 16,
    parameter int    AW        = 4,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: clear sweep, loader port, and 1-cycle fetch with fault flag.
module instr_mem_loadable
    import imem_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 16,
    parameter int                DEPTH          = 16,
    parameter bit                BYTE_ADDR      = 1'b1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter string             INIT_FILE      = "",
    parameter logic [DATA_W-1:0] NOP            = DATA_W'(IMEM_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_fault,
    input  logic              prog_mode,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err,
    output logic              busy
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [AW-1:0]     clear_cnt_q, clear_cnt_d;
    logic              load_err_q, load_err_d;
    logic              instr_valid_q, instr_valid_d;
    logic              instr_fault_q, instr_fault_d;
    logic              rd_sel_q, rd_sel_d;

    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_fault, load_oor, accept;
    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    // Range compares are one bit wider than the index so large PCs never alias.
    assign fetch_idx   = BYTE_ADDR ? (fetch_pc >> 1) : fetch_pc;
    assign fetch_fault = (BYTE_ADDR && fetch_pc[0]) || ({1'b0, fetch_idx} >= DEPTH_X);
    assign load_oor    = {1'b0, load_addr} >= DEPTH_X;
    assign fetch_ready = (state_q == ST_RUN) && !prog_mode;
    assign accept      = fetch_req && fetch_ready;

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        load_err_d  = load_err_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = fetch_idx[AW-1:0];
        ram_wdata   = load_data;
        case (state_q)
            ST_CLEAR: begin
                ram_we      = 1'b1;
                ram_addr    = clear_cnt_q;
                ram_wdata   = NOP;
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                ram_re = accept && !fetch_fault;
                if (prog_mode) begin
                    state_d    = ST_LOAD;
                    load_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                ram_addr = load_addr[AW-1:0];
                if (load_we) begin
                    if (load_oor) load_err_d = 1'b1;
                    else          ram_we     = 1'b1;
                end
                if (!prog_mode) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output registers: faults and reset select NOP instead of the RAM read port.
    always_comb begin
        instr_valid_d = accept;
        instr_fault_d = accept ? fetch_fault  : instr_fault_q;
        rd_sel_d      = accept ? !fetch_fault : rd_sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clear_cnt_q   <= '0;
            load_err_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_fault_q <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_cnt_q   <= clear_cnt_d;
            load_err_q    <= load_err_d;
            instr_valid_q <= instr_valid_d;
            instr_fault_q <= instr_fault_d;
            rd_sel_q      <= rd_sel_d;
        end
    end

    imem_sp_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign instr_valid = instr_valid_q;
    assign instr_fault = instr_fault_q;
    assign instruction = rd_sel_q ? ram_rdata : NOP;
    assign load_err    = load_err_q;
    assign busy        = (state_q != ST_RUN);

endmodule
